// File: rtl/digit_pkg.sv
// Shared constants and types for the output evaluator.
package digit_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int ACT_W       = 8;
  localparam int COST_W      = 16;
  localparam int ACC_W       = 20;
  localparam int TARGET_ONE  = 255;

  typedef enum logic [1:0] {IDLE, COLLECT, FINISH, DONE} eval_state_t;

  typedef logic [3:0] label_t;

endpackage

// File: rtl/sq_err_unit.sv
// Registered squared error of one activation against its 0/full-scale target.
// Only compiled when OUTPUT_EVAL_COST_EN is defined.
`ifdef OUTPUT_EVAL_COST_EN
module sq_err_unit
  import digit_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     value,
  input  logic                  is_target,
  input  logic                  vld,
  output logic [2*DATA_W-1:0]   sq_p1,
  output logic                  vld_p1
);

  // |value - target| squared equals e^2; the magnitude never exceeds full scale.
  function automatic logic [2*DATA_W-1:0] sq_err(input logic [DATA_W-1:0] v,
                                                 input logic tgt);
    logic [DATA_W-1:0] mag;
    mag = tgt ? (DATA_W'(TARGET_ONE) - v) : v;
    return {{DATA_W{1'b0}}, mag} * {{DATA_W{1'b0}}, mag};
  endfunction

  // stage p0 -> p1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld;
  end

  always_ff @(posedge clk) begin
    if (vld) sq_p1 <= sq_err(value, is_target);
  end

endmodule
`endif

// File: rtl/output_evaluator.sv
// Arg-max and squared-error cost over the ten serial output activations.
// Cost path present only when OUTPUT_EVAL_COST_EN is defined.
module output_evaluator #(
  parameter int DATA_W      = 8,
  parameter int NUM_CLASSES = 10,
  parameter int COST_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              calculate_cost,
  input  logic [3:0]        expected_label,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] out_value,
  output logic              out_ready,
  output logic [3:0]        detected_digit,
  output logic [COST_W-1:0] cost_output,
  output logic              network_done,
  output logic              cost_ready
);
  import digit_pkg::*;

  localparam label_t LAST_IDX = label_t'(NUM_CLASSES - 1);

  eval_state_t       state;
  label_t            idx;
  label_t            arg_idx;
  logic [DATA_W-1:0] max_val;
  logic              beat;

  // A start in the same cycle as a beat discards the beat.
  assign out_ready    = (state == COLLECT);
  assign beat         = out_valid && out_ready && !start;
  assign network_done = (state == DONE) && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      arg_idx        <= '0;
      max_val        <= '0;
      detected_digit <= '0;
    end else if (start) begin
      state          <= COLLECT;
      idx            <= '0;
      arg_idx        <= '0;
      max_val        <= '0;
      detected_digit <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (beat) begin
            idx <= idx + 1'b1;
            // Strictly greater keeps the lower index on ties.
            if (idx == '0 || out_value > max_val) begin
              max_val <= out_value;
              arg_idx <= idx;
            end
            if (idx == LAST_IDX) state <= FINISH;
          end
        end
        FINISH: begin
          state          <= DONE;
          detected_digit <= arg_idx;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_EVAL_COST_EN
  logic                  calc_lat;
  label_t                label_lat;
  logic [2*DATA_W-1:0]   sq_p1;
  logic                  vld_p1;
  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      acc_next;

  sq_err_unit #(.DATA_W(DATA_W)) u_sq_err (
    .clk       (clk),
    .rst       (rst),
    .value     (out_value),
    .is_target (idx == label_lat),
    .vld       (beat),
    .sq_p1     (sq_p1),
    .vld_p1    (vld_p1)
  );

  assign acc_next = acc + (vld_p1 ? {{(ACC_W-2*DATA_W){1'b0}}, sq_p1} : '0);

  // stage p1 -> accumulator; FINISH folds in the last square while reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      calc_lat    <= 1'b0;
      label_lat   <= '0;
      cost_output <= '0;
    end else if (start) begin
      acc         <= '0;
      calc_lat    <= calculate_cost;
      label_lat   <= expected_label;
      cost_output <= '0;
    end else begin
      acc <= acc_next;
      if (state == FINISH) cost_output <= acc_next[ACC_W-1 -: COST_W];
    end
  end

  assign cost_ready = network_done && calc_lat;
`else
  logic unused_cost_in;
  assign unused_cost_in = ^{calculate_cost, expected_label};
  assign cost_output    = '0;
  assign cost_ready     = 1'b0;
`endif

endmodule

// File: tb/tb_output_evaluator.sv
// Directed and randomized checks of output_evaluator against an array-based model.
module tb_output_evaluator;

`ifdef OUTPUT_EVAL_COST_EN
  localparam bit COST_EN = 1'b1;
`else
  localparam bit COST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        calculate_cost;
  logic [3:0]  expected_label;
  logic        out_valid;
  logic [7:0]  out_value;
  logic        out_ready;
  logic [3:0]  detected_digit;
  logic [15:0] cost_output;
  logic        network_done;
  logic        cost_ready;

  int total = 0;
  int bad   = 0;
  int vals[10];

  always #5 clk = ~clk;

  output_evaluator dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .calculate_cost (calculate_cost),
    .expected_label (expected_label),
    .out_valid      (out_valid),
    .out_value      (out_value),
    .out_ready      (out_ready),
    .detected_digit (detected_digit),
    .cost_output    (cost_output),
    .network_done   (network_done),
    .cost_ready     (cost_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int label, input bit calc);
    @(negedge clk);
    start          = 1'b1;
    calculate_cost = calc;
    expected_label = 4'(label);
    out_valid      = 1'b0;
    @(negedge clk);
    start          = 1'b0;
    calculate_cost = 1'($urandom);
    expected_label = 4'($urandom);
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          out_valid = 1'b0;
          out_value = 8'($urandom);
          @(negedge clk);
        end
      end
      out_valid = 1'b1;
      out_value = 8'(vals[i]);
      @(negedge clk);
    end
    out_valid = 1'b0;
  endtask

  // Called at the first negedge after the last beat was accepted.
  task automatic check_finish(input string tag, input int label, input bit calc);
    int best, err, t, exp_cost;
    best = 0;
    err  = 0;
    for (int i = 0; i < 10; i++) begin
      if (vals[i] > vals[best]) best = i;
      t   = (i == label) ? 255 : 0;
      err += (vals[i] - t) * (vals[i] - t);
    end
    exp_cost = COST_EN ? (err >> 4) : 0;
    check({tag, ".done_early"}, network_done, 0);
    @(negedge clk);
    check({tag, ".done"},   network_done, 1);
    check({tag, ".cready"}, cost_ready, (COST_EN && calc) ? 1 : 0);
    check({tag, ".digit"},  detected_digit, best);
    check({tag, ".cost"},   cost_output, exp_cost);
    @(negedge clk);
    check({tag, ".done_off"},  network_done, 0);
    check({tag, ".cready_off"}, cost_ready, 0);
    check({tag, ".digit_hold"}, detected_digit, best);
    check({tag, ".cost_hold"},  cost_output, exp_cost);
    check({tag, ".ready_off"},  out_ready, 0);
  endtask

  task automatic run_image(input string tag, input int label, input bit calc, input bit gaps);
    do_start(label, calc);
    check({tag, ".ready"}, out_ready, 1);
    feed(10, gaps);
    check_finish(tag, label, calc);
  endtask

  initial begin
    logic [3:0]  hold_d;
    logic [15:0] hold_c;
    rst = 1'b1; start = 1'b0; calculate_cost = 1'b0; expected_label = '0;
    out_valid = 1'b0; out_value = '0;
    #1;
    check("rst.ready", out_ready, 0);
    check("rst.digit", detected_digit, 0);
    check("rst.cost",  cost_output, 0);
    check("rst.done",  network_done, 0);
    check("rst.cready", cost_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) vals[i] = (i == 3) ? 255 : 0;
    run_image("case1", 3, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) vals[i] = (i == 7) ? 200 : 10;
    run_image("case2", 7, 1'b1, 1'b0);

    // beats offered while idle must not disturb held results
    hold_d = detected_digit;
    hold_c = cost_output;
    out_valid = 1'b1;
    repeat (3) begin out_value = 8'($urandom); @(negedge clk); end
    out_valid = 1'b0;
    check("idle.digit", detected_digit, hold_d);
    check("idle.cost",  cost_output, hold_c);
    check("idle.done",  network_done, 0);

    for (int i = 0; i < 10; i++) vals[i] = 255;
    run_image("case3", 0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) vals[i] = (i == 2 || i == 5) ? 180 : 0;
    run_image("case4", 4, 1'b0, 1'b1);

    // restart after four beats; only the fresh ten count
    for (int i = 0; i < 10; i++) vals[i] = 250 - i;
    do_start(9, 1'b1);
    feed(4, 1'b0);
    for (int i = 0; i < 10; i++) vals[i] = (i == 6) ? 240 : 20 + i;
    run_image("abort", 6, 1'b1, 1'b0);

    // start during DONE suppresses the pulse and clears results
    for (int i = 0; i < 10; i++) vals[i] = (i == 8) ? 230 : 5;
    do_start(8, 1'b1);
    feed(10, 1'b0);
    @(negedge clk);
    start = 1'b1; calculate_cost = 1'b1; expected_label = 4'd1;
    #1;
    check("sup.done",   network_done, 0);
    check("sup.cready", cost_ready, 0);
    @(negedge clk);
    start = 1'b0;
    check("sup.digit", detected_digit, 0);
    check("sup.cost",  cost_output, 0);
    check("sup.ready", out_ready, 1);
    for (int i = 0; i < 10; i++) vals[i] = (i == 1) ? 255 : 60;
    feed(10, 1'b0);
    check_finish("sup", 1, 1'b1);

    // reset with results held, then reset mid-collect
    rst = 1'b1;
    #1;
    check("rsth.digit", detected_digit, 0);
    check("rsth.cost",  cost_output, 0);
    @(negedge clk);
    rst = 1'b0;
    do_start(2, 1'b1);
    vals[0] = 9; vals[1] = 99; vals[2] = 250;
    feed(3, 1'b0);
    rst = 1'b1;
    #1;
    check("rstm.ready", out_ready, 0);
    check("rstm.done",  network_done, 0);
    @(negedge clk);
    rst = 1'b0;
    out_valid = 1'b1;
    repeat (3) begin out_value = 8'($urandom); @(negedge clk); end
    out_valid = 1'b0;
    check("rstm.ready_stay", out_ready, 0);
    check("rstm.digit", detected_digit, 0);
    check("rstm.cost",  cost_output, 0);
    for (int i = 0; i < 10; i++) vals[i] = (i == 4) ? 128 : 127;
    run_image("recover", 4, 1'b1, 1'b1);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 10; i++)
        vals[i] = (n % 3 == 0) ? 85 * $urandom_range(0, 3) : $urandom_range(0, 255);
      run_image($sformatf("rand%0d", n), $urandom_range(0, 15), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
